// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// The package name is kept short because other shared-resource controllers import it.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } arb_state_e;

  // Index width for n requesters. Never zero, so a 1-requester build still has a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NUM_REQ_DEFAULT = 4;
  localparam int unsigned IDX_W           = idx_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester and shared-register bus of the write arbiter.
// The master side is the requesters plus the external register; the slave side is the arbiter.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [IW-1:0]            gnt_id;
  logic                     reg_load;
  logic [WIDTH-1:0]         reg_d;
  logic [WIDTH-1:0]         reg_q;

  modport master (
    output req,
    output wdata,
    output reg_q,
    input  gnt,
    input  gnt_id,
    input  reg_load,
    input  reg_d
  );

  modport slave (
    input  req,
    input  wdata,
    input  reg_q,
    output gnt,
    output gnt_id,
    output reg_load,
    output reg_d
  );

endinterface

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin first-set finder: returns the first set req bit at or above ptr,
// wrapping from n-1 to 0. It has no state, so any shared-resource controller can reuse it.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  int unsigned pos;

  // Scan from the farthest offset down to ptr, so the nearest set bit is the last one to win.
  always_comb begin
    found = |req;
    idx   = '0;
    pos   = 0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      pos = (int'(ptr) + off) % N;
      if (req[pos]) begin
        idx = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write sequencer for one shared load-enabled register: arbitrate, load for one
// cycle, check the readback, then acknowledge the winner. Every output is registered.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_write_arbiter_if.slave   bus,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_W-1:0]     wr_count
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic                load_q, load_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]       id_q, id_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                found;
  logic [IW-1:0]       pick;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = found ? LOAD : IDLE;
      LOAD:    state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: computes the values the output registers take at the next edge, so the
  // strobes line up with the state they belong to (load during LOAD, gnt during CHECK).
  always_comb begin
    load_d = 1'b0;
    gnt_d  = '0;
    data_d = data_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    busy_d = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d   = pick;
          data_d = bus.wdata[int'(pick)*WIDTH +: WIDTH];
          load_d = 1'b1;
        end
      end
      LOAD: begin
        gnt_d = NUM_REQ'(1) << id_q;
        ptr_d = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
      CHECK: begin
        // The register captured at the end of LOAD, so q is valid for the whole CHECK cycle.
        if (bus.reg_q != data_q) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q <= 1'b0;
      data_q <= '0;
      gnt_q  <= '0;
      id_q   <= '0;
      ptr_q  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      load_q <= load_d;
      data_q <= data_d;
      gnt_q  <= gnt_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.reg_load = load_q;
  assign bus.reg_d    = data_q;
  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = id_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign wr_count     = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a 4-requester instance with an 8-bit counter and a
// 2-requester instance with a 2-bit counter, each next to its own model of the shared register.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) a ();
  reg_write_arbiter_if #(.NUM_REQ(2), .WIDTH(4)) b ();

  logic       busy_a, err_a, busy_b, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  reg_write_arbiter #(.NUM_REQ(4), .WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (a.slave),
    .busy     (busy_a),
    .err      (err_a),
    .wr_count (cnt_a)
  );

  reg_write_arbiter #(.NUM_REQ(2), .WIDTH(4), .CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b.slave),
    .busy     (busy_b),
    .err      (err_b),
    .wr_count (cnt_b)
  );

  // Shared registers; force_zero models a broken readback path on the first one.
  logic [3:0] shreg_a = 4'h0;
  logic [3:0] shreg_b = 4'h0;
  logic       force_zero = 1'b0;
  always @(posedge clk) if (a.reg_load) shreg_a <= a.reg_d;
  always @(posedge clk) if (b.reg_load) shreg_b <= b.reg_d;
  assign a.reg_q = force_zero ? 4'h0 : shreg_a;
  assign b.reg_q = shreg_b;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n  = 1'b0;
    a.req  = '0;
    b.req  = '0;
    tick();
    tick();
    rst_n  = 1'b1;
  endtask

  // Returns 0 if no grant shows up within the budget; the caller's check then fails.
  task automatic wait_gnt(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a.gnt != '0) begin
        g = a.gnt;
        break;
      end
    end
  endtask

  logic [3:0] g;
  logic [3:0] seq3 [3] = '{4'b0100, 4'b0001, 4'b0100};
  int         seen;

  initial begin
    a.req   = '0;
    a.wdata = '0;
    b.req   = '0;
    b.wdata = '0;
    do_reset();

    // 1: reset state, then a single write with its latency
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_load", 32'(a.reg_load), 32'd0);
    chk("rst_gnt", 32'(a.gnt), 32'd0);
    chk("rst_gnt_id", 32'(a.gnt_id), 32'd0);
    chk("rst_reg_d", 32'(a.reg_d), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    a.wdata = 16'h000A;
    a.req   = 4'b0001;
    tick();
    chk("t1_load", 32'(a.reg_load), 32'd1);
    chk("t1_reg_d", 32'(a.reg_d), 32'hA);
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_gnt_early", 32'(a.gnt), 32'd0);
    tick();
    chk("t1_gnt", 32'(a.gnt), 32'b0001);
    chk("t1_load_off", 32'(a.reg_load), 32'd0);
    chk("t1_q", 32'(shreg_a), 32'hA);
    chk("t1_cnt", 32'(cnt_a), 32'd1);
    a.req = '0;
    tick();
    chk("t1_gnt_one_cycle", 32'(a.gnt), 32'd0);
    chk("t1_idle", 32'(busy_a), 32'd0);
    chk("t1_err", 32'(err_a), 32'd0);
    chk("t1_d_hold", 32'(a.reg_d), 32'hA);

    // 2: all four at once, each drops after its grant
    do_reset();
    a.wdata = 16'h8421;
    a.req   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g);
      chk($sformatf("t2_gnt%0d", i), 32'(g), 32'(1 << i));
      a.req = a.req & ~g;
    end
    tick();
    chk("t2_q", 32'(shreg_a), 32'h8);
    chk("t2_cnt", 32'(cnt_a), 32'd4);

    // 3: req0 held, req2 joins after the first grant -> 0,2,0,2
    do_reset();
    a.wdata = 16'h0301;
    a.req   = 4'b0001;
    wait_gnt(g);
    chk("t3_gnt0", 32'(g), 32'b0001);
    a.req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(g);
      chk($sformatf("t3_gnt%0d", i + 1), 32'(g), 32'(seq3[i]));
    end
    a.req = '0;

    // 4: readback fault is sticky across a clean write, cleared by reset
    do_reset();
    force_zero = 1'b1;
    a.wdata    = 16'h003C;
    a.req      = 4'b0001;
    wait_gnt(g);
    chk("t4_gnt", 32'(g), 32'b0001);
    a.req = '0;
    tick();
    chk("t4_err", 32'(err_a), 32'd1);
    force_zero = 1'b0;
    a.req      = 4'b0010;
    wait_gnt(g);
    chk("t4_gnt2", 32'(g), 32'b0010);
    a.req = '0;
    tick();
    chk("t4_q_clean", 32'(shreg_a), 32'h3);
    chk("t4_err_sticky", 32'(err_a), 32'd1);
    chk("t4_cnt", 32'(cnt_a), 32'd2);
    do_reset();
    chk("t4_err_cleared", 32'(err_a), 32'd0);

    // 5: reset during LOAD; pointer must return to 0 (it was 2 before)
    a.wdata = 16'h0650;
    a.req   = 4'b0010;
    wait_gnt(g);
    chk("t5_pre_gnt", 32'(g), 32'b0010);
    a.req = '0;
    tick();
    a.req = 4'b0100;
    tick();
    chk("t5_in_load", 32'(a.reg_load), 32'd1);
    chk("t5_gnt_id2", 32'(a.gnt_id), 32'd2);
    rst_n = 1'b0;
    tick();
    chk("t5_busy", 32'(busy_a), 32'd0);
    chk("t5_gnt", 32'(a.gnt), 32'd0);
    chk("t5_load", 32'(a.reg_load), 32'd0);
    chk("t5_id", 32'(a.gnt_id), 32'd0);
    rst_n = 1'b1;
    a.req = 4'b0110;
    tick();
    chk("t5_ptr0_pick", 32'(a.gnt_id), 32'd1);
    tick();
    chk("t5_gnt_after", 32'(a.gnt), 32'b0010);
    a.req = '0;
    tick();

    // 6: 2-bit counter saturates; wdata changes after capture are ignored
    do_reset();
    b.wdata = 8'h06;
    b.req   = 2'b01;
    tick();
    b.wdata = 8'h09;
    chk("t6_d_capt", 32'(b.reg_d), 32'h6);
    tick();
    chk("t6_d_stable", 32'(b.reg_d), 32'h6);
    chk("t6_q", 32'(shreg_b), 32'h6);
    chk("t6_gnt", 32'(b.gnt), 32'b01);
    chk("t6_cnt1", 32'(cnt_b), 32'd1);
    seen = 1;
    for (int i = 0; i < 30 && seen < 5; i++) begin
      tick();
      if (b.gnt != '0) seen++;
    end
    chk("t6_writes", 32'(seen), 32'd5);
    b.req = '0;
    tick();
    chk("t6_cnt_sat", 32'(cnt_b), 32'd3);
    chk("t6_q_new", 32'(shreg_b), 32'h9);
    chk("t6_err", 32'(err_b), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
